gb_loader: RTL

//   Write-side front end of the global buffer: accepts an 8-bit byte stream over a

---
 rtl/gb_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gb_loader.sv
// Write-side front end of the global buffer: turns a valid/ready byte stream into
// fmaps/weight bank writes with one cycle of latency and a done pulse per load.
module gb_loader #(
  parameter int unsigned FMAPS_WORDS  = 32,
  parameter int unsigned WEIGHT_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [1:0] cs,
  output logic [1:0] we,
  output logic [7:0] data_o,
  output logic [4:0] fmaps_addr,
  output logic [5:0] weight_addr,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned FA_W  = 5;
  localparam int unsigned WA_W  = 6;
  localparam int unsigned D_W   = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FMAPS  = 2'd1;
  localparam logic [1:0] ST_WEIGHT = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FMAPS_WORDS - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wload_q, wload_d;
  logic [1:0]       cs_q, cs_d;
  logic [D_W-1:0]   data_q, data_d;
  logic [FA_W-1:0]  faddr_q, faddr_d;
  logic [WA_W-1:0]  waddr_q, waddr_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             beat_c;

  // in_ready_q mirrors "state is LOAD_*", so it doubles as the handshake qualifier
  assign beat_c = in_valid & in_ready_q;

  // Next state, beat counter and registered write-port values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wload_d = wload_q;
    cs_d    = 2'b00;
    data_d  = data_q;
    faddr_d = faddr_q;
    waddr_d = waddr_q;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wload_d = mode[1];
            cnt_d   = '0;
            if (mode[0])      state_d = ST_FMAPS;
            else if (mode[1]) state_d = ST_WEIGHT;
            else              state_d = ST_FIN;
          end
        end
        ST_FMAPS: begin
          if (beat_c) begin
            cs_d    = 2'b01;
            data_d  = in_data;
            faddr_d = FA_W'(cnt_q);
            if (cnt_q == F_LAST) begin
              cnt_d   = '0;
              state_d = wload_q ? ST_WEIGHT : ST_FIN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WEIGHT: begin
          if (beat_c) begin
            cs_d    = 2'b10;
            data_d  = in_data;
            waddr_d = WA_W'(cnt_q);
            if (cnt_q == W_LAST) begin
              cnt_d   = '0;
              state_d = ST_FIN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    in_ready_d = (state_d == ST_FMAPS) || (state_d == ST_WEIGHT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wload_q    <= 1'b0;
      cs_q       <= 2'b00;
      data_q     <= '0;
      faddr_q    <= '0;
      waddr_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wload_q    <= wload_d;
      cs_q       <= cs_d;
      data_q     <= data_d;
      faddr_q    <= faddr_d;
      waddr_q    <= waddr_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign cs          = cs_q;
  assign we          = cs_q;
  assign data_o      = data_q;
  assign fmaps_addr  = faddr_q;
  assign weight_addr = waddr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
